// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit: funct3 codes, FSM states, op helpers.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package muldiv_pkg;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    localparam int         CNT_W    = 5;
    localparam logic [4:0] CNT_INIT = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } md_state_t;

    // Divide/remainder ops all have funct3[2] set.
    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    // rs1 is treated as two's complement for these ops. MUL is listed as signed;
    // its low word is the same either way.
    function automatic logic is_signed_a(input logic [2:0] op);
        return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
               (op == MD_DIV) || (op == MD_REM);
    endfunction

    // rs2 is treated as two's complement for these ops (MULHSU keeps rs2 unsigned).
    function automatic logic is_signed_b(input logic [2:0] op);
        return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// EX-stage handshake between the ID/EX register and the mul/div engine.
// Latency: wires only.
// Backpressure: stall_req from the engine freezes PC, IF/ID and ID/EX while an op is in flight.
interface ex_muldiv_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic            stall_req;

    modport master (
        output flush, start, op, a, b,
        input  busy, done, result, stall_req
    );

    modport slave (
        input  flush, start, op, a, b,
        output busy, done, result, stall_req
    );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative radix-2 RV32M multiply/divide engine (shift-add multiply, restoring divide).
// Latency: 33 cycles accept-to-done; divide-by-zero and signed overflow finish in 1 cycle.
// Backpressure: stall_req = start & ~done & ~flush holds the pipeline until done pulses.
module ex_muldiv
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         rst,
    ex_muldiv_if.slave   md
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    md_state_t         state_q, state_d;
    logic [2:0]        op_q;
    logic              neg_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2*XLEN-1:0] acc_q;      // product accumulator; low word is the partial remainder when dividing
    logic [XLEN-1:0]   mq_q;       // multiplier (shifts right) or dividend/quotient (shifts left)
    logic [XLEN-1:0]   md_q;       // multiplicand or divisor magnitude
    logic [XLEN-1:0]   result_q;

    // Accept-time decode
    logic              accept;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_zero, div_ovf, special;
    logic [XLEN-1:0]   special_res;
    logic              neg_d;

    // One iteration of the datapath
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_acc;
    logic [XLEN:0]     rem_sh;
    logic              rem_ge;
    logic [XLEN-1:0]   rem_dif;
    logic [XLEN-1:0]   div_rem;
    logic [XLEN-1:0]   div_quo;

    // Final-result selection and sign fix-up
    logic [XLEN-1:0]   div_raw;
    logic [2*XLEN-1:0] fin_raw;
    logic [2*XLEN-1:0] fin_fix;
    logic [XLEN-1:0]   result_d;

    assign accept = (state_q == ST_IDLE) && md.start && !md.flush;

    // Operand magnitudes, negate flag and one-cycle special cases decided at accept
    always_comb begin
        a_neg       = is_signed_a(md.op) & md.a[XLEN-1];
        b_neg       = is_signed_b(md.op) & md.b[XLEN-1];
        a_mag       = a_neg ? (~md.a + 1'b1) : md.a;
        b_mag       = b_neg ? (~md.b + 1'b1) : md.b;
        div_zero    = is_div(md.op) && (md.b == '0);
        div_ovf     = ((md.op == MD_DIV) || (md.op == MD_REM)) &&
                      (md.a == INT_MIN) && (md.b == '1);
        special     = div_zero || div_ovf;
        special_res = '0;
        if (div_zero) begin
            special_res = md.op[1] ? md.a : '1;
        end else if (div_ovf) begin
            special_res = md.op[1] ? '0 : INT_MIN;
        end
        // Remainder takes the dividend's sign; everything else is sign(a) ^ sign(b).
        if (is_div(md.op) && md.op[1]) begin
            neg_d = a_neg;
        end else begin
            neg_d = a_neg ^ b_neg;
        end
    end

    // Shift-add and restoring-subtract step plus the negate mux feeding result_q
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (mq_q[0] ? {1'b0, md_q} : '0);
        mul_acc  = {mul_sum, acc_q[XLEN-1:1]};
        rem_sh   = {acc_q[XLEN-1:0], mq_q[XLEN-1]};
        rem_ge   = rem_sh >= {1'b0, md_q};
        // When rem_ge holds the difference is below the divisor, so XLEN bits suffice.
        rem_dif  = rem_sh[XLEN-1:0] - md_q;
        div_rem  = rem_ge ? rem_dif : rem_sh[XLEN-1:0];
        div_quo  = {mq_q[XLEN-2:0], rem_ge};
        div_raw  = op_q[1] ? div_rem : div_quo;
        fin_raw  = is_div(op_q) ? {{XLEN{1'b0}}, div_raw} : mul_acc;
        fin_fix  = neg_q ? (~fin_raw + 1'b1) : fin_raw;
        result_d = (is_div(op_q) || (op_q == MD_MUL)) ? fin_fix[XLEN-1:0]
                                                      : fin_fix[2*XLEN-1:XLEN];
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: flush wins over start; start in DONE is ignored
    always_comb begin
        state_d = state_q;
        if (md.flush) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: if (md.start) state_d = special ? ST_DONE : ST_CALC;
                ST_CALC: if (cnt_q == '0) state_d = ST_DONE;
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath registers: load on accept, iterate in CALC, capture result on the last step
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= MD_MUL;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mq_q     <= '0;
            md_q     <= '0;
            result_q <= '0;
        end else if (md.flush) begin
            // result_q deliberately survives a flush
            op_q  <= MD_MUL;
            neg_q <= 1'b0;
            cnt_q <= '0;
            acc_q <= '0;
            mq_q  <= '0;
            md_q  <= '0;
        end else if (accept) begin
            op_q  <= md.op;
            neg_q <= neg_d;
            cnt_q <= CNT_INIT;
            acc_q <= '0;
            if (is_div(md.op)) begin
                mq_q <= a_mag;
                md_q <= b_mag;
            end else begin
                mq_q <= b_mag;
                md_q <= a_mag;
            end
            if (special) begin
                result_q <= special_res;
            end
        end else if (state_q == ST_CALC) begin
            cnt_q <= cnt_q - 1'b1;
            if (is_div(op_q)) begin
                acc_q <= {{XLEN{1'b0}}, div_rem};
                mq_q  <= div_quo;
            end else begin
                acc_q <= mul_acc;
                mq_q  <= {1'b0, mq_q[XLEN-1:1]};
            end
            if (cnt_q == '0) begin
                result_q <= result_d;
            end
        end
    end

    assign md.busy      = (state_q != ST_IDLE);
    assign md.done      = (state_q == ST_DONE);
    assign md.result    = result_q;
    assign md.stall_req = md.start & ~md.done & ~md.flush;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv: all eight ops, special cases, flush, reset, back-to-back.
// Latency: checks 33-cycle normal and 1-cycle special accept-to-done.
// Backpressure: checks stall_req across accept, CALC and the done cycle.
module tb_ex_muldiv;
    import muldiv_pkg::*;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_errs;

    ex_muldiv_if #(.XLEN(32)) mif ();

    ex_muldiv #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .md  (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at the negedge of cycle 1 after accept; returns the cycle number of done.
    task automatic wait_done(output int lat, output bit stall_ok);
        lat      = 1;
        stall_ok = 1'b1;
        while (mif.done !== 1'b1 && lat < 100) begin
            if (mif.stall_req !== 1'b1) stall_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
    endtask

    // Issue one op from IDLE, scramble the operands after accept, and check the outcome.
    task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] exp_res,
                         input int exp_lat, output int acc_cyc);
        int lat;
        bit sok;
        @(negedge clk);
        mif.start = 1'b1;
        mif.op    = o;
        mif.a     = av;
        mif.b     = bv;
        acc_cyc   = cyc;
        #1;
        check({tag, "_stall_accept"}, {31'b0, mif.stall_req}, 32'd1);
        check({tag, "_done_accept"}, {31'b0, mif.done}, 32'd0);
        @(negedge clk);
        mif.a = ~av;
        mif.b = 32'h0;
        wait_done(lat, sok);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_result"}, mif.result, exp_res);
        check({tag, "_stall_calc"}, {31'b0, sok}, 32'd1);
        check({tag, "_stall_done"}, {31'b0, mif.stall_req}, 32'd0);
        mif.start = 1'b0;
    endtask

    initial begin
        int c0, c1;
        int lat;
        bit sok;
        n_checks  = 0;
        n_errs    = 0;
        cyc       = 0;
        rst       = 1'b1;
        mif.flush = 1'b0;
        mif.start = 1'b0;
        mif.op    = MD_MUL;
        mif.a     = '0;
        mif.b     = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, mif.busy}, 32'd0);
        check("rst_done", {31'b0, mif.done}, 32'd0);
        check("rst_result", mif.result, 32'd0);
        check("rst_stall", {31'b0, mif.stall_req}, 32'd0);
        rst = 1'b0;

        do_op("mul",    MD_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, c0);
        do_op("mulh",   MD_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33, c0);
        do_op("mulhu",  MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, c0);
        do_op("mulhsu", MD_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33, c0);
        do_op("div",    MD_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, c0);
        do_op("rem",    MD_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, c0);
        do_op("divu",   MD_DIVU,   32'd100,      32'd7,        32'd14,       33, c0);
        do_op("remu",   MD_REMU,   32'd100,      32'd7,        32'd2,        33, c0);
        do_op("divu_z", MD_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1,  c0);
        do_op("rem_z",  MD_REM,    32'd5,        32'd0,        32'd5,        1,  c0);
        do_op("rem_ov", MD_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  c0);
        do_op("div_ov", MD_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  c0);

        // Flush a DIV in cycle 10, then accept a REMU in cycle 11 while start stays high.
        @(negedge clk);
        mif.start = 1'b1;
        mif.op    = MD_DIV;
        mif.a     = 32'd100;
        mif.b     = 32'd7;
        repeat (10) @(negedge clk);
        mif.flush = 1'b1;
        #1;
        check("flush_stall", {31'b0, mif.stall_req}, 32'd0);
        @(negedge clk);
        mif.flush = 1'b0;
        check("flush_busy", {31'b0, mif.busy}, 32'd0);
        check("flush_done", {31'b0, mif.done}, 32'd0);
        check("flush_result_hold", mif.result, 32'h80000000);
        mif.op = MD_REMU;
        #1;
        check("flush_restart_stall", {31'b0, mif.stall_req}, 32'd1);
        @(negedge clk);
        wait_done(lat, sok);
        check("flush_restart_latency", lat, 32'd33);
        check("flush_restart_result", mif.result, 32'd2);
        check("flush_restart_stall_calc", {31'b0, sok}, 32'd1);
        mif.start = 1'b0;

        // Back-to-back MULs: 34-cycle issue interval, independent results.
        do_op("b2b_first",  MD_MUL, 32'd6,        32'd7,        32'd42, 33, c0);
        do_op("b2b_second", MD_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,  33, c1);
        check("b2b_interval", c1 - c0, 32'd34);
        @(negedge clk);
        check("b2b_result_hold", mif.result, 32'd1);
        check("b2b_done_pulse", {31'b0, mif.done}, 32'd0);

        // Reset in the middle of CALC.
        mif.start = 1'b1;
        mif.op    = MD_MUL;
        mif.a     = 32'd3;
        mif.b     = 32'd5;
        repeat (6) @(negedge clk);
        check("mid_busy", {31'b0, mif.busy}, 32'd1);
        rst       = 1'b1;
        mif.start = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", {31'b0, mif.busy}, 32'd0);
        check("mid_rst_done", {31'b0, mif.done}, 32'd0);
        check("mid_rst_result", mif.result, 32'd0);
        check("mid_rst_stall", {31'b0, mif.stall_req}, 32'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("post_rst_no_done", {31'b0, mif.done}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative RV32M multiply/divide unit in the EX stage, consuming the operands and op code held in the ID/EX pipeline register. One radix-2 engine computes all eight M-extension ops in 32 iterations. While an op is in flight it raises a stall request that freezes PC, IF/ID and ID/EX. When the result is ready it pulses `done` so EX can forward the result into EX/MEM.

## Interface
- `XLEN`, 32, operand/result width; only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  abort the current op; same timing as the ID/EX flush.
- `start`  in  1  ID/EX holds a valid M-extension instruction.
- `op`  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `a`, `b`  in  XLEN  rs1 and rs2 values, already forwarded.
- `busy`  out  1  engine not IDLE (registered).
- `done`  out  1  one-cycle pulse; `result` valid (registered).
- `result`  out  XLEN  final value; holds until the next accept.
- `stall_req`  out  1  combinational: `start & ~done & ~flush`.

## Operation
- States: IDLE, CALC, DONE.
- **Accept.** In IDLE with `start=1` and `flush=0`:
  - latch op;
  - latch operand magnitudes (per op signedness: MULHSU treats `a` signed, `b` unsigned);
  - latch the result-negate flag;
  - clear the 64-bit accumulator;
  - load count=31;
  - go to CALC.
- **Multiply.**
  - Shift-add on magnitudes, one multiplier bit per cycle, 64-bit product.
  - Negate the product if the sign flag is set.
  - MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
- **Divide.**
  - Restoring division on magnitudes, one quotient bit per cycle.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - Unsigned ops never negate.
- **Special cases.** Detected at accept; go straight to DONE with a fixed result:
  - divide by zero: DIV/DIVU quotient = all ones; REM/REMU remainder = `a`;
  - signed overflow (`a`=0x80000000, `b`=0xFFFFFFFF): DIV = 0x80000000, REM = 0.
- **CALC.** Decrement count each cycle; after the count=0 iteration, go to DONE.
- **DONE.**
  - Drive `done=1` and the sign-fixed `result`.
  - Go to IDLE unconditionally.
  - `start` seen in DONE is not accepted.
- If EX is frozen by another hazard while `done` pulses, `start` stays high in the next IDLE cycle and the op re-executes. The result is identical; no corruption.
- **Flush/reset.**
  - `flush` or `rst` in any state: go to IDLE at the next edge; no `done`.
  - `busy=0`; count, accumulator and latched op are cleared.
  - `result` is cleared only by `rst`.
  - `flush` has priority over `start` in the same cycle.
- **Reset values:** busy=0, done=0, result=0, stall_req=0 (start low), state=IDLE.

## Timing
- Accept edge = cycle 0.
- Normal op: CALC occupies cycles 1..32; `done`=1 in cycle 33. Latency is 33 cycles accept-to-done for all ops.
- Special case: DONE in cycle 1, so `done`=1 one cycle after accept.
- `stall_req`:
  - high combinationally in the accept cycle and every cycle until `done`;
  - low in the `done` cycle, so ID/EX advances on that edge.
- Back-to-back ops: the next `start` is accepted the cycle after `done` (IDLE), giving a 34-cycle issue interval.
- Operands `a`/`b` may change after accept without effect.

## Structure
- Shared package `muldiv_pkg`:
  - op funct3 constants (MD_MUL … MD_REMU);
  - state enum (ST_IDLE, ST_CALC, ST_DONE);
  - `is_div(op)` and `is_signed_a/b(op)` helper functions.
- No sub-module. The datapath (64-bit accumulator, 33-bit subtractor/adder, 5-bit counter) and FSM live in `ex_muldiv`.
- Sign fix-up is a single negate mux on the output register input.

## Test plan
- MUL a=7, b=0xFFFFFFFD (-3) -> `done` at cycle 33, result=0xFFFFFFEB; stall_req high cycles 0..32.
- MULH a=b=0x80000000 -> 0x40000000; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2.
- DIVU a=5, b=0 -> 0xFFFFFFFF with `done` at cycle 1; REM a=5, b=0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0, both `done` at cycle 1.
- `flush` at cycle 10 of a DIV -> no `done`, busy=0 at cycle 11; `start` with new op at cycle 11 accepted and completes at cycle 44.
- `rst` mid-CALC -> all outputs 0 the next cycle. Two back-to-back MULs -> `done` at cycles 33 and 67 with correct independent results.
